// File: rtl/aes_pkg.sv
// AES byte/word types, GF(2^8) helpers, S-boxes and one-step key expansion.
// Shared by the unrolled encryptor and the iterative decryptor.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    KEYEXP,
    DEC,
    DONE
  } state_t;

  localparam byte_t RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic byte_t xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(byte_t a, byte_t b);
    byte_t r = 8'h00;
    byte_t p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  function automatic byte_t mul9(byte_t b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic byte_t mul11(byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic byte_t mul13(byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic byte_t mul14(byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0
  function automatic byte_t gf_inv(byte_t a);
    byte_t r = 8'h01;
    byte_t p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic byte_t rotl(byte_t b, int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic byte_t sbox(byte_t a);
    byte_t x = gf_inv(a);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  function automatic byte_t inv_sbox(byte_t a);
    return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic word_t sub_word(word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic word_t inv_mix_col(word_t w);
    byte_t a0 = w[31:24];
    byte_t a1 = w[23:16];
    byte_t a2 = w[15:8];
    byte_t a3 = w[7:0];
    return {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
            mul9(a0) ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
            mul13(a0) ^ mul9(a1) ^ mul14(a2) ^ mul11(a3),
            mul11(a0) ^ mul13(a1) ^ mul9(a2) ^ mul14(a3)};
  endfunction

  function automatic block_t expand_key(block_t k, byte_t rc);
    word_t t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    word_t n0 = k[127:96] ^ t;
    word_t n1 = k[95:64] ^ n0;
    word_t n2 = k[63:32] ^ n1;
    word_t n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then optional InvMixColumns. Purely combinational.
module inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] key,
  input  logic         mix,
  output logic [127:0] state_out
);

  logic [127:0] ark;
  logic [127:0] mixed;

  // byte r+4c comes from column (c-r) mod 4 of the same row
  always_comb begin
    ark = '0;
    for (int i = 0; i < 16; i++) begin
      ark[127-8*i -: 8] =
        inv_sbox(state_in[127-8*((i%4)+4*(((i/4)+4-(i%4))%4)) -: 8])
        ^ key[127-8*i -: 8];
    end
  end

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end
  end

  assign state_out = mix ? mixed : ark;

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor: cached key schedule built one round key
// per cycle, then ten inverse rounds, one per cycle.
module aes128_decrypt_iter
  import aes_pkg::*;
#(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  state_t       state;
  block_t       rk [0:10];
  logic         key_cached;
  block_t       st;
  block_t       ct;
  logic [3:0]   rnd;
  logic [3:0]   kcnt;
  block_t       nk;
  block_t       dec_out;
  logic         hit;

  assign nk  = expand_key(rk[kcnt - 4'd1], RCON[kcnt]);
  assign hit = KEY_CACHE && key_cached && (in_key == rk[0]);

  inv_round u_round (
    .state_in  (st),
    .key       (rk[rnd]),
    .mix       (rnd != 4'd0),
    .state_out (dec_out)
  );

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = st;

  // rk is left unreset on purpose; key_cached says whether it is usable
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      key_cached <= 1'b0;
      st         <= '0;
      ct         <= '0;
      rnd        <= '0;
      kcnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ct <= in_data;
            if (hit) begin
              st    <= in_data ^ rk[10];
              rnd   <= 4'd9;
              state <= DEC;
            end else begin
              rk[0]      <= in_key;
              key_cached <= 1'b0;
              kcnt       <= 4'd1;
              state      <= KEYEXP;
            end
          end
        end
        KEYEXP: begin
          rk[kcnt] <= nk;
          if (kcnt == 4'd10) begin
            st         <= ct ^ nk;
            key_cached <= 1'b1;
            rnd        <= 4'd9;
            state      <= DEC;
          end else begin
            kcnt <= kcnt + 4'd1;
          end
        end
        DEC: begin
          st <= dec_out;
          if (rnd == 4'd0) state <= DONE;
          else rnd <= rnd - 4'd1;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter: known-answer table, handshake corner
// cases and random traffic checked against a local AES-128 encryptor.
module tb_aes128_decrypt_iter;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
  } vec_t;

  typedef struct {
    logic [127:0] pt;
    int           acc;
    int           lat;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         busy;

  logic         nc_in_valid = 1'b0;
  logic         nc_in_ready;
  logic         nc_out_valid;
  logic [127:0] nc_out_data;
  logic         nc_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rise_cyc = 0;
  bit ov_prev = 1'b0;
  bit rand_mode = 1'b0;

  logic [127:0] cur_exp = '0;
  int           cur_lat = 0;
  logic [127:0] mc_key = '0;
  bit           mc_valid = 1'b0;
  sb_t          sb [$];
  logic [7:0]   sb_tab [256];

  aes128_decrypt_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  aes128_decrypt_iter #(.KEY_CACHE(1'b0)) dut_nc (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (nc_in_valid),
    .in_ready  (nc_in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (nc_out_valid),
    .out_ready (out_ready),
    .out_data  (nc_out_data),
    .busy      (nc_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_mode) begin
      #2;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from walking the multiplicative group with generator 3
  task automatic build_sbox();
    logic [7:0] p = 8'h01;
    logic [7:0] q = 8'h01;
    logic [7:0] x;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sb_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb_tab[0] = 8'h63;
  endtask

  function automatic logic [127:0] enc(input logic [127:0] k,
                                       input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc = 8'h01;
    logic [31:0]  tmp;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r = '0;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]],
               sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++)
      s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++)
        t[i] = sb_tab[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rd < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  // input side of the scoreboard
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready)
      sb.push_back('{pt: cur_exp, acc: cyc, lat: cur_lat});
  end

  // output side of the scoreboard
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) rise_cyc = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %h want none", out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.pt);
          if (e.lat != 0) chki("latency", rise_cyc - e.acc, e.lat);
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input logic [127:0] k, input logic [127:0] c,
                      input logic [127:0] p, input int lat, input bit hold);
    bit ok = 1'b0;
    in_key = k;
    in_data = c;
    cur_exp = p;
    cur_lat = lat;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    mc_key = k;
    mc_valid = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
    sb.delete();
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl [5];
    logic [127:0] k, p, prev;
    int           t0, lat;
    bit           seen;

    tbl[0] = '{key: K1, ct: C1, pt: P1, lat: 21};
    tbl[1] = '{key: K1, ct: C1, pt: P1, lat: 11};
    tbl[2] = '{key: K2, ct: C2, pt: P2, lat: 21};
    tbl[3] = '{key: K2, ct: C2, pt: P2, lat: 11};
    tbl[4] = '{key: K1, ct: C1, pt: P1, lat: 21};
    build_sbox();

    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("idle_in_ready", in_ready, 1'b1);
    chk1("idle_out_valid", out_valid, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chk("idle_out_data", out_data, '0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      send(tbl[i].key, tbl[i].ct, tbl[i].pt, tbl[i].lat, 1'b0);
      drain();
    end

    // backpressure in DONE with ignored input pulses
    out_ready = 1'b0;
    send(K2, C2, P2, 21, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk1("bp_reached_done", seen, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk1("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_data", out_data, P2);
      chk1("bp_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      in_data = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk1("bp_release_in_ready", in_ready, 1'b1);
    chk1("bp_release_out_valid", out_valid, 1'b0);
    chki("bp_pending", sb.size(), 0);
    @(posedge clk);
    #1;

    // reset in the middle of a new-key decrypt
    send(K1, C1, P1, 21, 1'b0);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk1("midrst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    mc_valid = 1'b0;
    @(negedge clk);
    chk1("midrst_in_ready_after", in_ready, 1'b1);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk("midrst_out_data", out_data, '0);
    @(posedge clk);
    #1;
    send(K1, C1, P1, 21, 1'b0);
    drain();

    // no key cache: every block re-expands
    for (int n = 0; n < 2; n++) begin
      in_key = K1;
      in_data = C1;
      nc_in_valid = 1'b1;
      t0 = -1;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (nc_in_ready) begin
          t0 = cyc;
          break;
        end
      end
      @(posedge clk);
      #1 nc_in_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (nc_out_valid) begin
          seen = 1'b1;
          break;
        end
      end
      chk1("nc_done", seen, 1'b1);
      chki("nc_latency", cyc - t0, 21);
      chk("nc_out_data", nc_out_data, P1);
      @(posedge clk);
      #1;
    end

    // random back-to-back traffic with random out_ready
    rand_mode = 1'b1;
    prev = K1;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 2) == 0) k = prev;
      else k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      lat = (mc_valid && k == mc_key) ? 11 : 21;
      send(k, enc(k, p), p, lat, 1'b1);
      prev = k;
    end
    in_valid = 1'b0;
    rand_mode = 1'b0;
    @(posedge clk);
    #3 out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
